ram_banked_ctrl: RTL and testbench
==================================

// Module: ram_banked_ctrl
// PURPOSE
//  Parametrised data-memory subsystem for the ucontroller: decodes one CPU bus into a register region and
//  NUM_BANKS general-purpose RAM banks. Adds registered reads with a valid strobe, post-reset zero-fill of all
//  GP banks, and an access-error flag for unmapped or blocked accesses. Sits between the CPU/DMA bus mux and memory.
// PARAMETERS
//  DATA_W      8           data word width
//  ADDR_W      8           bus address width
//  GP_BASE     8'h40       first GP address; [0, GP_BASE) is the register region
//  NUM_BANKS   4           GP banks; bank = (Address-GP_BASE)/BANK_DEPTH
//  BANK_DEPTH  32          words per bank (power of 2); GP region ends at GP_BASE+NUM_BANKS*BANK_DEPTH-1
// PORTS
//  Clk        in   1       clock, all state on rising edge
//  Rst        in   1       synchronous reset, active-high
//  Cs         in   1       access select
//  Wen        in   1       write enable (qualified by Cs)
//  Oen        in   1       read enable (qualified by Cs)
//  Address    in   ADDR_W  word address
//  DataIn     in   DATA_W  write data
//  DataOut    out  DATA_W  registered read data
//  RdValid    out  1       one-cycle pulse: DataOut updated
//  Busy       out  1       zero-fill in progress
//  AccessErr  out  1       one-cycle pulse: unmapped address, or access while Busy
//  ParityErr  out  1       one-cycle pulse with RdValid on GP parity mismatch
//  Switches   out  DATA_W  contents of register REG_SWITCHES
//  Temp       out  DATA_W  contents of register REG_TEMP
// BEHAVIOUR
//  - Reset: DataOut=0, RdValid=0, AccessErr=0, ParityErr=0, all register-region words=0 (Switches=Temp=0), FSM=CLEAR, ClrPtr=0, Busy=1.
//  - FSM CLEAR: every cycle writes 0 at ClrPtr in all banks in parallel; ClrPtr++. When ClrPtr==BANK_DEPTH-1 the write completes and the FSM goes READY next cycle.
//    Busy=1 for exactly BANK_DEPTH cycles after reset is released. FSM READY: Busy=0; it stays there until Rst.
//  - Rst asserted mid-CLEAR restarts the fill at ClrPtr=0. Rst asserted in READY re-enters CLEAR.
//  - Write: Cs&Wen in READY. Data is stored at the clock edge. Register region: word Address. GP: bank/offset decode.
//  - Read: Cs&Oen&~Wen in READY. DataOut and RdValid=1 are updated on the next edge (latency 1).
//    DataOut holds its last value while RdValid=0.
//  - Cs&Wen&Oen together: the write wins. No read, RdValid=0.
//  - A write at cycle N followed by a read of the same address at N+1 returns the new data at N+2.
//  - Address >= GP_BASE+NUM_BANKS*BANK_DEPTH: no write. A read returns DataOut=0 with RdValid=1. AccessErr=1 next cycle.
//  - Any Cs access while Busy: ignored (no write, RdValid=0), AccessErr=1 next cycle.
//  - Register region words without an assigned function are plain read/write storage.
//  - Address arithmetic is unsigned at ADDR_W. The offset uses log2(BANK_DEPTH) LSBs of (Address-GP_BASE).
// CONFIGURATION
//  RAM_PARITY_EN defined: each GP word stores DATA_W+1 bits, the extra bit being even parity of the data, written on
//   every write (fill writes parity 0). A GP read with mismatch gives ParityErr=1 in the RdValid cycle; DataOut is still the stored data.
//  RAM_PARITY_EN undefined: banks are DATA_W wide, no parity logic, ParityErr tied to 0.
// STRUCTURE
//  global_pkg: GP_RAM_BASE default, REG_SWITCHES / REG_TEMP addresses, typedef enum {CLEAR, READY} ram_fsm_t.
//  Sub-module ram_bank: single-port synchronous RAM (DEPTH x WIDTH, registered read). Instantiated NUM_BANKS times via generate.
//  Top: decode, FSM, register region, read mux, error/parity flags.
// TESTING
//  1 Release Rst, default params -> Busy=1 for 32 cycles then 0. A read of 8'h40 and of 8'hBF returns 0.
//  2 Write 8'hA5 @8'h45, read @8'h45 next cycle -> DataOut=8'hA5 with RdValid one cycle after the read.
//  3 Write 8'h3C @REG_SWITCHES -> Switches=8'h3C after the edge. Temp unchanged (0).
//  4 Read @8'hC0 -> DataOut=0, RdValid=1, AccessErr=1. A write there leaves all banks unchanged.
//  5 Access during Busy -> ignored, AccessErr pulse. Assert Rst at ClrPtr=10 -> Busy lasts another 32 cycles from release.
//  6 RAM_PARITY_EN: write 8'h01 @8'h60, force-flip the stored parity bit, read -> DataOut=8'h01, ParityErr=1. Without the macro -> ParityErr=0.

Source files
------------

// File: rtl/ram_banked_ctrl_pkg.sv
// Shared constants and types for the banked data-memory subsystem.
// Build option: define RAM_PARITY_EN to store an even-parity bit with every GP word.
package ram_banked_ctrl_pkg;
    localparam logic [7:0] GP_RAM_BASE  = 8'h40;
    localparam logic [7:0] REG_SWITCHES = 8'h10;
    localparam logic [7:0] REG_TEMP     = 8'h11;

    typedef enum logic {CLEAR, READY} ram_fsm_t;

    // Which storage the last read came from; selects the held DataOut source.
    typedef enum logic [1:0] {SRC_ZERO, SRC_REG, SRC_GP} rd_src_t;
endpackage

// File: rtl/ram_banked_ctrl_if.sv
// CPU-side bus of the banked data memory: request signals in, read data and status out.
interface ram_banked_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              Cs;
    logic              Wen;
    logic              Oen;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              RdValid;
    logic              Busy;
    logic              AccessErr;
    logic              ParityErr;
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] Temp;

    modport master (
        output Cs, Wen, Oen, Address, DataIn,
        input  DataOut, RdValid, Busy, AccessErr, ParityErr, Switches, Temp
    );
    modport slave (
        input  Cs, Wen, Oen, Address, DataIn,
        output DataOut, RdValid, Busy, AccessErr, ParityErr, Switches, Temp
    );
endinterface

// File: rtl/ram_banked_ctrl_bank.sv
// Single-port synchronous RAM bank; the read register only loads on re_i, so it holds between reads.
module ram_banked_ctrl_bank #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_banked_ctrl.sv
// Data-memory subsystem: register region below GP_BASE, NUM_BANKS GP RAM banks above it,
// post-reset zero-fill, access-error flag. Define RAM_PARITY_EN for per-word parity checking.
module ram_banked_ctrl
    import ram_banked_ctrl_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] GP_BASE  = ADDR_W'(GP_RAM_BASE),
    parameter int              NUM_BANKS  = 4,
    parameter int              BANK_DEPTH = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    ram_banked_ctrl_if.slave bus
);
    localparam int OFF_W  = $clog2(BANK_DEPTH);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NREG   = int'(GP_BASE);
    localparam int REG_AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int GP_END = NREG + NUM_BANKS * BANK_DEPTH;
`ifdef RAM_PARITY_EN
    localparam int BW = DATA_W + 1;
`else
    localparam int BW = DATA_W;
`endif

    ram_fsm_t                         state_q, state_d;
    logic [OFF_W-1:0]                 clr_ptr_q, clr_ptr_d;
    logic [NREG-1:0][DATA_W-1:0]      regs_q;
    logic [DATA_W-1:0]                reg_rd_q;
    rd_src_t                          src_q;
    logic [BANK_W-1:0]                rsel_q;
    logic                             rd_vld_q, aerr_q;

    logic [NUM_BANKS-1:0]             bank_we, bank_re;
    logic [OFF_W-1:0]                 bank_addr;
    logic [BW-1:0]                    bank_wd, gp_wd, gp_q;
    logic [NUM_BANKS-1:0][BW-1:0]     bank_q;

    logic              ready, is_reg, is_gp, wr, rd, bad;
    logic [ADDR_W-1:0] rel;
    logic [OFF_W-1:0]  off;
    logic [BANK_W-1:0] bsel;
    logic [REG_AW-1:0] ridx;

    assign ready  = (state_q == READY);
    assign is_reg = 32'(bus.Address) < 32'(NREG);
    assign is_gp  = !is_reg && (32'(bus.Address) < 32'(GP_END));
    assign rel    = bus.Address - GP_BASE;
    assign off    = rel[OFF_W-1:0];
    assign bsel   = BANK_W'(rel >> OFF_W);
    assign ridx   = bus.Address[REG_AW-1:0];

    // Write beats read when both enables are high.
    assign wr  = bus.Cs & bus.Wen & ready;
    assign rd  = bus.Cs & bus.Oen & ~bus.Wen & ready;
    assign bad = bus.Cs & (~ready | ((bus.Wen | bus.Oen) & ~is_reg & ~is_gp));

`ifdef RAM_PARITY_EN
    assign gp_wd = {^bus.DataIn, bus.DataIn};
`else
    assign gp_wd = bus.DataIn;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // CLEAR zeroes one offset in every bank per cycle; READY routes bus accesses.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        bank_we   = '0;
        bank_re   = '0;
        bank_addr = off;
        bank_wd   = gp_wd;
        case (state_q)
            CLEAR: begin
                bank_we   = '1;
                bank_addr = clr_ptr_q;
                bank_wd   = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == OFF_W'(BANK_DEPTH - 1)) state_d = READY;
            end
            READY: begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    bank_we[b] = wr & is_gp & (bsel == BANK_W'(b));
                    bank_re[b] = rd & is_gp & (bsel == BANK_W'(b));
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q   <= '0;
            reg_rd_q <= '0;
            src_q    <= SRC_ZERO;
            rsel_q   <= '0;
            rd_vld_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            rd_vld_q <= rd;
            aerr_q   <= bad;
            if (wr && is_reg) regs_q[ridx] <= bus.DataIn;
            if (rd) begin
                src_q  <= is_reg ? SRC_REG : (is_gp ? SRC_GP : SRC_ZERO);
                rsel_q <= bsel;
                if (is_reg) reg_rd_q <= regs_q[ridx];
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_banked_ctrl_bank #(.DEPTH(BANK_DEPTH), .WIDTH(BW)) u_bank (
            .clk_i   (clk_i),
            .we_i    (bank_we[g]),
            .re_i    (bank_re[g]),
            .addr_i  (bank_addr),
            .wdata_i (bank_wd),
            .rdata_o (bank_q[g])
        );
    end

    // Every source is a register that only reloads on a read, so DataOut holds between reads.
    assign gp_q = bank_q[rsel_q];

    always_comb begin
        bus.DataOut = '0;
        case (src_q)
            SRC_REG: bus.DataOut = reg_rd_q;
            SRC_GP:  bus.DataOut = gp_q[DATA_W-1:0];
            default: bus.DataOut = '0;
        endcase
    end

`ifdef RAM_PARITY_EN
    assign bus.ParityErr = rd_vld_q && (src_q == SRC_GP) && ((^gp_q[DATA_W-1:0]) != gp_q[DATA_W]);
`else
    assign bus.ParityErr = 1'b0;
`endif

    assign bus.RdValid   = rd_vld_q;
    assign bus.AccessErr = aerr_q;
    assign bus.Busy      = (state_q == CLEAR);
    assign bus.Switches  = regs_q[REG_SWITCHES[REG_AW-1:0]];
    assign bus.Temp      = regs_q[REG_TEMP[REG_AW-1:0]];
endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Bench for ram_banked_ctrl: reset/fill timing, table of bus accesses with a read scoreboard,
// busy-time accesses, reset restart mid-fill, and parity handling.
module tb_ram_banked_ctrl;
    import ram_banked_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_banked_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    ram_banked_ctrl #(
        .DATA_W(8), .ADDR_W(8), .GP_BASE(8'h40), .NUM_BANKS(4), .BANK_DEPTH(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       cs, we, oe;
        logic [7:0] addr, din;
        logic       vld;
        logic [7:0] dout;
        logic       aerr;
        logic [7:0] sw, tmp;
    } vec_t;

`ifdef RAM_PARITY_EN
    localparam logic EXP_PERR_FLIP = 1'b1;
`else
    localparam logic EXP_PERR_FLIP = 1'b0;
`endif

    vec_t       tbl [24];
    logic [7:0] sbq [$];
    logic [7:0] last_dout;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic we, input logic oe,
                         input logic [7:0] addr, input logic [7:0] din);
        bus.Cs      = cs;
        bus.Wen     = we;
        bus.Oen     = oe;
        bus.Address = addr;
        bus.DataIn  = din;
    endtask

    function automatic vec_t mk(input logic cs, input logic we, input logic oe,
                                input logic [7:0] addr, input logic [7:0] din,
                                input logic vld, input logic [7:0] dout, input logic aerr);
        vec_t v;
        v.cs = cs; v.we = we; v.oe = oe; v.addr = addr; v.din = din;
        v.vld = vld; v.dout = dout; v.aerr = aerr; v.sw = 8'h00; v.tmp = 8'h00;
        return v;
    endfunction

    task automatic busy_len(input string nm);
        int n;
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk(nm, n, 32);
    endtask

    // Push expected data when the read is driven; pop when RdValid appears.
    task automatic sb_read(input string nm, input logic [7:0] addr, input logic [7:0] exp);
        drive(1'b1, 1'b0, 1'b1, addr, 8'h00);
        sbq.push_back(exp);
        step();
        chk({nm, "_vld"}, bus.RdValid, 1'b1);
        chk({nm, "_sb_depth"}, sbq.size(), 1);
        if (bus.RdValid === 1'b1 && sbq.size() > 0) begin
            last_dout = sbq.pop_front();
            chk({nm, "_dout"}, bus.DataOut, last_dout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        cs  we  oe  addr   din    vld dout   aerr
        tbl[0]  = mk(1, 0, 1, 8'h40, 8'h00, 1, 8'h00, 0);
        tbl[1]  = mk(1, 0, 1, 8'hBF, 8'h00, 1, 8'h00, 0);
        tbl[2]  = mk(1, 1, 0, 8'h45, 8'hA5, 0, 8'h00, 0);
        tbl[3]  = mk(1, 0, 1, 8'h45, 8'h00, 1, 8'hA5, 0);
        tbl[4]  = mk(1, 1, 0, 8'h10, 8'h3C, 0, 8'h00, 0);
        tbl[5]  = mk(1, 0, 1, 8'hC0, 8'h00, 1, 8'h00, 1);
        tbl[6]  = mk(1, 1, 0, 8'hC0, 8'h77, 0, 8'h00, 1);
        tbl[7]  = mk(1, 0, 1, 8'hFF, 8'h00, 1, 8'h00, 1);
        tbl[8]  = mk(1, 1, 0, 8'h7F, 8'h5A, 0, 8'h00, 0);
        tbl[9]  = mk(1, 0, 1, 8'h7F, 8'h00, 1, 8'h5A, 0);
        tbl[10] = mk(1, 1, 0, 8'hBF, 8'h99, 0, 8'h00, 0);
        tbl[11] = mk(1, 0, 1, 8'hBF, 8'h00, 1, 8'h99, 0);
        tbl[12] = mk(1, 1, 1, 8'h46, 8'h22, 0, 8'h00, 0);
        tbl[13] = mk(1, 0, 1, 8'h46, 8'h00, 1, 8'h22, 0);
        tbl[14] = mk(1, 0, 1, 8'h40, 8'h00, 1, 8'h00, 0);
        tbl[15] = mk(1, 1, 0, 8'h11, 8'hE1, 0, 8'h00, 0);
        tbl[16] = mk(1, 0, 1, 8'h11, 8'h00, 1, 8'hE1, 0);
        tbl[17] = mk(1, 1, 0, 8'h20, 8'h44, 0, 8'h00, 0);
        tbl[18] = mk(1, 0, 1, 8'h20, 8'h00, 1, 8'h44, 0);
        tbl[19] = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        tbl[20] = mk(0, 1, 0, 8'h41, 8'h10, 0, 8'h00, 0);
        tbl[21] = mk(1, 0, 1, 8'h41, 8'h00, 1, 8'h00, 0);
        tbl[22] = mk(1, 0, 1, 8'h10, 8'h00, 1, 8'h3C, 0);
        tbl[23] = mk(1, 0, 0, 8'h45, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 24; i++) begin
            tbl[i].sw  = (i >= 4)  ? 8'h3C : 8'h00;
            tbl[i].tmp = (i >= 15) ? 8'hE1 : 8'h00;
        end

        last_dout = 8'h00;
        drive(0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        repeat (3) step();
        chk("rst_dout",  bus.DataOut,   8'h00);
        chk("rst_vld",   bus.RdValid,   1'b0);
        chk("rst_aerr",  bus.AccessErr, 1'b0);
        chk("rst_perr",  bus.ParityErr, 1'b0);
        chk("rst_sw",    bus.Switches,  8'h00);
        chk("rst_tmp",   bus.Temp,      8'h00);
        chk("rst_busy",  bus.Busy,      1'b1);

        rst = 1'b0;
        busy_len("fill_len");

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].cs, tbl[i].we, tbl[i].oe, tbl[i].addr, tbl[i].din);
            if (tbl[i].vld) sbq.push_back(tbl[i].dout);
            step();
            chk($sformatf("v%0d_vld", i), bus.RdValid, tbl[i].vld);
            if (bus.RdValid === 1'b1) begin
                chk($sformatf("v%0d_sb_depth", i), sbq.size(), 1);
                if (sbq.size() > 0) begin
                    last_dout = sbq.pop_front();
                    chk($sformatf("v%0d_dout", i), bus.DataOut, last_dout);
                end
            end else begin
                chk($sformatf("v%0d_hold", i), bus.DataOut, last_dout);
            end
            chk($sformatf("v%0d_aerr", i), bus.AccessErr, tbl[i].aerr);
            chk($sformatf("v%0d_sw", i),   bus.Switches,  tbl[i].sw);
            chk($sformatf("v%0d_tmp", i),  bus.Temp,      tbl[i].tmp);
            chk($sformatf("v%0d_perr", i), bus.ParityErr, 1'b0);
        end

        // Reset from READY re-enters CLEAR and wipes the register region.
        drive(0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_dout = 8'h00;
        chk("rerst_sw",   bus.Switches, 8'h00);
        chk("rerst_dout", bus.DataOut,  8'h00);
        chk("rerst_busy", bus.Busy,     1'b1);

        drive(1, 1, 0, 8'h45, 8'hEE);
        step();
        chk("busy_wr_aerr", bus.AccessErr, 1'b1);
        chk("busy_wr_vld",  bus.RdValid,   1'b0);
        drive(1, 0, 1, 8'h45, 8'h00);
        step();
        chk("busy_rd_aerr", bus.AccessErr, 1'b1);
        chk("busy_rd_vld",  bus.RdValid,   1'b0);
        drive(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("busy_idle_aerr", bus.AccessErr, 1'b0);
        repeat (7) step();
        chk("clr_ptr_10", dut.clr_ptr_q, 10);

        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_len("refill_len");
        sb_read("refill_45", 8'h45, 8'h00);
        chk("refill_45_aerr", bus.AccessErr, 1'b0);

        // Parity: 8'h01 @8'h60 is bank 1, offset 0.
        drive(1, 1, 0, 8'h60, 8'h01);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
`ifdef RAM_PARITY_EN
        dut.g_bank[1].u_bank.mem_q[0][8] = ~dut.g_bank[1].u_bank.mem_q[0][8];
`endif
        sb_read("par_60", 8'h60, 8'h01);
        chk("par_60_perr", bus.ParityErr, EXP_PERR_FLIP);
        drive(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("par_idle_perr", bus.ParityErr, 1'b0);
        chk("par_idle_hold", bus.DataOut,   8'h01);
        sb_read("par_61", 8'h61, 8'h00);
        chk("par_61_perr", bus.ParityErr, 1'b0);

        drive(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("sb_drain", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
